hsp_merge_filter: RTL and testbench
===================================

# hsp_merge_filter

- Downstream consumer of the HSP FIFO; pops high-scoring pairs (subject pos, query pos, length, score).
- Discards HSPs scoring below a runtime threshold.
- Merges consecutive HSPs that lie on the same diagonal and overlap or abut.
- Presents surviving, merged HSPs on a valid/ready output to the reporting stage.

## Interface
Parameters:
- W, 8: field width of s/q/l/score; matches the FIFO field width.
- CW, 16: width of the statistics counters.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-high.
- score_thresh  in  W  minimum score kept (unsigned; score >= thresh survives).
- flush  in  1  level request to emit the held HSP once the FIFO is drained.
- fifo_empty  in  1  FIFO empty flag.
- fifo_rd_en  out  1  FIFO read enable; registered single-cycle pulse.
- fifo_s, fifo_q, fifo_l, fifo_score  in  W each  FIFO read data; valid the cycle after fifo_rd_en is sampled. l==0 means no entry.
- out_valid  out  1  output HSP valid.
- out_ready  in  1  downstream accepts.
- out_s, out_q, out_l, out_score  out  W each  output HSP.
- cnt_in, cnt_drop, cnt_merge  out  CW each  counts of HSPs popped, dropped, and merged; wrap modulo 2^CW.

## Operation
- Internal state:
  - held register: hs, hq, hl, hscore, plus held_v.
  - output register.
  - FSM with states IDLE, RD, CAP.
- IDLE:
  - if !fifo_empty and !out_valid: go to RD.
  - else if flush and fifo_empty and held_v and !out_valid: load the output register from held, clear held_v, stay in IDLE.
- RD: fifo_rd_en=1 for this cycle only; go to CAP.
- CAP: evaluate fifo_* (new HSP n), then go to IDLE. Evaluation order:
  - n.l==0: ignore; no counter changes.
  - Otherwise cnt_in++. Then:
    - n.score < score_thresh: cnt_drop++; held unchanged.
    - else if !held_v: held <= n.
    - else if same diagonal and overlapping (rules below): merge into held; cnt_merge++.
    - else: output register <= held; held <= n.
- Diagonal test: (n.s - n.q) mod 2^W == (hs - hq) mod 2^W.
- Overlap test: n.q >= hq and n.q <= hq + hl, with the sum computed in W+1 bits (abutting counts as overlap).
- Merge result:
  - hs, hq unchanged.
  - end = max(hq+hl, n.q+n.l) in W+1 bits.
  - hl = end - hq, saturated to 2^W-1.
  - hscore = max(hscore, n.score).
- Output register loads only when out_valid==0, so no overwrite is possible; reads are issued only when out_valid==0.
- Handshake: out_valid stays high with stable data until the cycle where out_valid & out_ready, then clears at the next edge.

## Timing
- Reset (synchronous, clk edge with rst=1):
  - FSM to IDLE; held_v=0.
  - fifo_rd_en=0, out_valid=0, all out_* = 0, all counters = 0.
  - rst mid-RD/CAP abandons the in-flight read; that FIFO entry is lost (the FIFO still pops it).
- Throughput: one FIFO pop per 3 cycles (IDLE→RD→CAP).
- Latency, FIFO data to held update: edge ending CAP.
- Latency, emit to out_valid: held appears on out_valid 1 cycle after the CAP or IDLE-flush decision edge.
- Backpressure: while out_valid && !out_ready, the FSM stays in IDLE and fifo_rd_en stays 0.
- fifo_empty is sampled only in IDLE; no read is issued on an empty FIFO.
- flush with held_v=0 has no effect. flush is ignored while the FIFO is non-empty; draining takes priority.
- Arithmetic: all diagonal arithmetic wraps modulo 2^W; the end computation must not wrap (W+1 bits).

## Test plan
- Reset: hold rst 2 cycles mid-RD.
  - Required: outputs, counters, and fifo_rd_en are 0; state IDLE; held_v=0.
- Single HSP, thresh=20: FIFO holds (s=10, q=4, l=6, score=30); then assert flush.
  - Required: out = (10, 4, 6, 30), out_valid until ready.
  - Required: cnt_in=1, drop=0, merge=0.
- Drop, thresh=20: entry (s=3, q=1, l=5, score=15).
  - Required: no output; cnt_in=1, cnt_drop=1.
- Merge: entries (10, 4, 6, 30) then (14, 8, 8, 25); both on diagonal 6, and 8 <= 10. Then flush.
  - Required: out = (10, 4, 12, 30); cnt_merge=1.
- Split with backpressure: entries (10, 4, 6, 30) then (20, 4, 3, 40); diagonals differ. Hold out_ready=0 for 10 cycles.
  - Required: out = (10, 4, 6, 30) holds stable; fifo_rd_en stays 0.
  - Then ready=1 and flush. Required: out = (20, 4, 3, 40).
- Saturation: entries (0, 0, 200, 50) then (150, 150, 200, 60).
  - Required: end=350, merged out_l=255, out_score=60.

Source files
------------

// File: rtl/hsp_merge_filter.sv
// hsp_merge_filter: pops HSPs from the upstream FIFO, drops low scorers,
// merges same-diagonal overlapping/abutting HSPs into a held entry and
// presents finished HSPs on a valid/ready output.
//
// Handshake: out_valid rises with out_* stable and stays high, data unchanged,
// until a cycle with out_valid && out_ready; out_valid clears at the next edge.
// The output register only loads while out_valid is low, and FIFO reads are
// only issued while out_valid is low.
module hsp_merge_filter #(
    parameter int W  = 8,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [W-1:0]  score_thresh,
    input  logic          flush,
    input  logic          fifo_empty,
    output logic          fifo_rd_en,
    input  logic [W-1:0]  fifo_s,
    input  logic [W-1:0]  fifo_q,
    input  logic [W-1:0]  fifo_l,
    input  logic [W-1:0]  fifo_score,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_s,
    output logic [W-1:0]  out_q,
    output logic [W-1:0]  out_l,
    output logic [W-1:0]  out_score,
    output logic [CW-1:0] cnt_in,
    output logic [CW-1:0] cnt_drop,
    output logic [CW-1:0] cnt_merge,
    output logic [1:0]    dbg_state,
    output logic          dbg_held_v
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        CAP  = 2'd2
    } state_t;

    state_t state, state_nx;

    // held HSP being grown by merges
    logic [W-1:0] hs, hq, hl, hscore;
    logic         held_v;

    // FSM decisions
    logic go_rd;
    logic do_flush;
    logic cap;

    // evaluation of the incoming HSP against the held one
    logic [W-1:0] n_diag, h_diag;
    logic [W:0]   h_end, n_end, m_end, m_span;
    logic [W-1:0] m_len, m_score;
    logic         n_valid, n_pass, same_diag, overlap, merge_hit;
    logic         do_first, do_merge, do_split, do_emit;

    // diagonal arithmetic wraps in W bits; end points are kept in W+1 bits
    assign n_diag    = fifo_s - fifo_q;
    assign h_diag    = hs - hq;
    assign same_diag = (n_diag == h_diag);
    assign h_end     = {1'b0, hq} + {1'b0, hl};
    assign n_end     = {1'b0, fifo_q} + {1'b0, fifo_l};
    assign overlap   = (fifo_q >= hq) && ({1'b0, fifo_q} <= h_end);
    assign merge_hit = same_diag && overlap;
    assign m_end     = (h_end >= n_end) ? h_end : n_end;
    assign m_span    = m_end - {1'b0, hq};
    assign m_len     = m_span[W] ? {W{1'b1}} : m_span[W-1:0];
    assign m_score   = (fifo_score > hscore) ? fifo_score : hscore;

    assign cap      = (state == CAP);
    assign n_valid  = (fifo_l != '0);
    assign n_pass   = (fifo_score >= score_thresh);
    assign do_first = cap && n_valid && n_pass && !held_v;
    assign do_merge = cap && n_valid && n_pass && held_v && merge_hit;
    assign do_split = cap && n_valid && n_pass && held_v && !merge_hit;
    assign do_emit  = do_split || do_flush;

    assign dbg_state  = state;
    assign dbg_held_v = held_v;

    // next-state logic: draining the FIFO beats a flush request
    always_comb begin
        state_nx = state;
        go_rd    = 1'b0;
        do_flush = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty && !out_valid) begin
                    state_nx = RD;
                    go_rd    = 1'b1;
                end else if (flush && fifo_empty && held_v && !out_valid) begin
                    do_flush = 1'b1;
                end
            end
            RD:      state_nx = CAP;
            CAP:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // state register and the registered read pulse (high exactly during RD)
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            fifo_rd_en <= 1'b0;
        end else begin
            state      <= state_nx;
            fifo_rd_en <= go_rd;
        end
    end

    // held entry: capture first survivor, grow on merge, replace on split
    always_ff @(posedge clk) begin
        if (rst) begin
            held_v <= 1'b0;
            hs     <= '0;
            hq     <= '0;
            hl     <= '0;
            hscore <= '0;
        end else if (do_flush) begin
            held_v <= 1'b0;
        end else if (do_first || do_split) begin
            held_v <= 1'b1;
            hs     <= fifo_s;
            hq     <= fifo_q;
            hl     <= fifo_l;
            hscore <= fifo_score;
        end else if (do_merge) begin
            hl     <= m_len;
            hscore <= m_score;
        end
    end

    // output register: load held on emit, drop valid on accepted handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_s     <= '0;
            out_q     <= '0;
            out_l     <= '0;
            out_score <= '0;
        end else if (do_emit) begin
            out_valid <= 1'b1;
            out_s     <= hs;
            out_q     <= hq;
            out_l     <= hl;
            out_score <= hscore;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // statistics counters, wrapping naturally at 2^CW
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_in    <= '0;
            cnt_drop  <= '0;
            cnt_merge <= '0;
        end else if (cap && n_valid) begin
            cnt_in <= cnt_in + CW'(1);
            if (!n_pass) begin
                cnt_drop <= cnt_drop + CW'(1);
            end
            if (do_merge) begin
                cnt_merge <= cnt_merge + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_hsp_merge_filter.sv
// Bench for hsp_merge_filter: a queue-based FIFO responder, a transaction-level
// reference model of the filter/merge rules, a per-cycle output scoreboard,
// directed scenarios with literal expectations and a randomized phase.
module tb_hsp_merge_filter;

  localparam int W  = 8;
  localparam int CW = 16;

  logic          clk;
  logic          rst;
  logic [W-1:0]  score_thresh;
  logic          flush;
  logic          fifo_empty;
  logic          fifo_rd_en;
  logic [W-1:0]  fifo_s, fifo_q, fifo_l, fifo_score;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_s, out_q, out_l, out_score;
  logic [CW-1:0] cnt_in, cnt_drop, cnt_merge;
  logic [1:0]    dbg_state;
  logic          dbg_held_v;

  hsp_merge_filter #(.W(W), .CW(CW)) dut (
    .clk(clk), .rst(rst), .score_thresh(score_thresh), .flush(flush),
    .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
    .fifo_s(fifo_s), .fifo_q(fifo_q), .fifo_l(fifo_l), .fifo_score(fifo_score),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_s(out_s), .out_q(out_q), .out_l(out_l), .out_score(out_score),
    .cnt_in(cnt_in), .cnt_drop(cnt_drop), .cnt_merge(cnt_merge),
    .dbg_state(dbg_state), .dbg_held_v(dbg_held_v)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int n_pass = 0;
  int n_total = 0;
  logic [4*W-1:0] exp_q[$];
  logic [4*W-1:0] fq[$];
  bit rand_ready = 0;

  // reference model state
  bit m_hv;
  int m_hs, m_hq, m_hl, m_hsc;
  int m_in, m_drop, m_merge;

  function automatic void check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h required %0h", nm, act, exp);
  endfunction

  function automatic logic [4*W-1:0] pack(input int a, input int b, input int c, input int d);
    return {a[W-1:0], b[W-1:0], c[W-1:0], d[W-1:0]};
  endfunction

  function automatic void model_reset();
    m_hv = 0; m_hs = 0; m_hq = 0; m_hl = 0; m_hsc = 0;
    m_in = 0; m_drop = 0; m_merge = 0;
    exp_q.delete();
  endfunction

  // what one popped entry does, from the filter/merge rules
  function automatic void model_pop(input logic [4*W-1:0] e);
    int s, q, l, sc, th, e_end;
    s  = int'(e[4*W-1:3*W]);
    q  = int'(e[3*W-1:2*W]);
    l  = int'(e[2*W-1:W]);
    sc = int'(e[W-1:0]);
    th = int'(score_thresh);
    if (l == 0) return;
    m_in++;
    if (sc < th) begin
      m_drop++;
    end else if (!m_hv) begin
      m_hv = 1; m_hs = s; m_hq = q; m_hl = l; m_hsc = sc;
    end else if (((s - q + 256) % 256) == ((m_hs - m_hq + 256) % 256)
                 && q >= m_hq && q <= m_hq + m_hl) begin
      e_end = (m_hq + m_hl > q + l) ? m_hq + m_hl : q + l;
      m_hl  = (e_end - m_hq > 255) ? 255 : e_end - m_hq;
      m_hsc = (sc > m_hsc) ? sc : m_hsc;
      m_merge++;
    end else begin
      exp_q.push_back(pack(m_hs, m_hq, m_hl, m_hsc));
      m_hv = 1; m_hs = s; m_hq = q; m_hl = l; m_hsc = sc;
    end
  endfunction

  function automatic void model_flush();
    if (m_hv) begin
      exp_q.push_back(pack(m_hs, m_hq, m_hl, m_hsc));
      m_hv = 0;
    end
  endfunction

  // ---------------- FIFO responder ----------------
  // rd_en is high for the whole RD cycle; data is driven at mid-RD and held
  initial begin
    logic [4*W-1:0] e;
    forever begin
      @(negedge clk);
      if (fifo_rd_en) begin
        check("rd_on_nonempty", fq.size() == 0, 1'b0);
        if (fq.size() > 0) begin
          e = fq.pop_front();
          {fifo_s, fifo_q, fifo_l, fifo_score} = e;
          model_pop(e);
        end
        fifo_empty = (fq.size() == 0);
      end
    end
  end

  // random backpressure
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    end
  end

  // ---------------- compare process ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && out_valid) begin
        check("out_pending", exp_q.size() > 0, 1'b1);
        check("rd_during_valid", fifo_rd_en, 1'b0);
        if (exp_q.size() > 0) begin
          check("out_data", {out_s, out_q, out_l, out_score}, exp_q[0]);
          if (out_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push(input int s, input int q, input int l, input int sc);
    @(posedge clk);
    #1;
    fq.push_back(pack(s, q, l, sc));
    fifo_empty = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    flush = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic settle();
    int stable = 0;
    int k = 0;
    while (stable < 4 && k < 3000) begin
      @(negedge clk);
      k++;
      if (fq.size() == 0 && dbg_state == 2'd0 && !out_valid) stable++;
      else stable = 0;
    end
    check("settle_bound", stable >= 4, 1'b1);
  endtask

  task automatic wait_out(input string nm, input int s, input int q, input int l, input int sc);
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!out_valid && k < 60);
    check({nm, "_valid"}, out_valid, 1'b1);
    check({nm, "_data"}, {out_s, out_q, out_l, out_score}, pack(s, q, l, sc));
  endtask

  task automatic flush_expect(input string nm, input int s, input int q, input int l, input int sc);
    int k = 0;
    model_flush();
    @(posedge clk);
    #1;
    flush = 1'b1;
    wait_out(nm, s, q, l, sc);
    while (out_valid && k < 60) begin
      @(negedge clk);
      k++;
    end
    check({nm, "_accepted"}, out_valid, 1'b0);
    @(posedge clk);
    #1;
    flush = 1'b0;
  endtask

  task automatic check_cnts(input string nm, input int i, input int d, input int m);
    check({nm, "_cnt_in"}, cnt_in, CW'(i));
    check({nm, "_cnt_drop"}, cnt_drop, CW'(d));
    check({nm, "_cnt_merge"}, cnt_merge, CW'(m));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int k;
    int ls, lq, ll, s, q, l, sc;
    rst = 1'b1;
    flush = 1'b0;
    out_ready = 1'b1;
    score_thresh = 8'd20;
    fifo_empty = 1'b1;
    fifo_s = '0; fifo_q = '0; fifo_l = '0; fifo_score = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("init_outs", {fifo_rd_en, out_valid, out_s, out_q, out_l, out_score}, 64'd0);
    check_cnts("init", 0, 0, 0);
    check("init_state", dbg_state, 2'd0);

    // reset in the middle of a read, with an entry held
    push(5, 5, 5, 100);
    settle();
    check("pre_rst_held", dbg_held_v, 1'b1);
    push(7, 7, 3, 90);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!fifo_rd_en && k < 20);
    check("rd_seen", fifo_rd_en, 1'b1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rst_outs", {fifo_rd_en, out_valid, out_s, out_q, out_l, out_score}, 64'd0);
    check_cnts("rst", 0, 0, 0);
    check("rst_state", dbg_state, 2'd0);
    check("rst_held_v", dbg_held_v, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    check("post_rst_state", dbg_state, 2'd0);
    check("post_rst_held_v", dbg_held_v, 1'b0);
    // flush with nothing held does nothing
    flush = 1'b1;
    repeat (6) @(negedge clk);
    check("empty_flush_no_out", out_valid, 1'b0);
    flush = 1'b0;

    // single HSP
    do_reset();
    push(10, 4, 6, 30);
    settle();
    check_cnts("single", 1, 0, 0);
    flush_expect("single", 10, 4, 6, 30);

    // drop below threshold
    do_reset();
    push(3, 1, 5, 15);
    settle();
    check_cnts("drop", 1, 1, 0);
    check("drop_held_v", dbg_held_v, 1'b0);
    flush = 1'b1;
    repeat (6) @(negedge clk);
    check("drop_no_out", out_valid, 1'b0);
    flush = 1'b0;

    // merge on diagonal 6
    do_reset();
    push(10, 4, 6, 30);
    push(14, 8, 8, 25);
    settle();
    check_cnts("merge", 2, 0, 1);
    flush_expect("merge", 10, 4, 12, 30);

    // split with backpressure; a pending FIFO entry must not be read
    do_reset();
    out_ready = 1'b0;
    push(10, 4, 6, 30);
    push(20, 4, 3, 40);
    push(50, 50, 5, 5);
    wait_out("split", 10, 4, 6, 30);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_hold", {out_valid, out_s, out_q, out_l, out_score}, {1'b1, pack(10, 4, 6, 30)});
      check("bp_no_rd", fifo_rd_en, 1'b0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    settle();
    check_cnts("split", 3, 1, 0);
    flush_expect("split2", 20, 4, 3, 40);

    // length saturation
    do_reset();
    push(0, 0, 200, 50);
    push(150, 150, 200, 60);
    settle();
    check_cnts("sat", 2, 0, 1);
    flush_expect("sat", 0, 0, 255, 60);

    // zero-length ignored, score == thresh kept, overlap past 2^W, abut
    do_reset();
    push(1, 1, 0, 99);
    push(2, 250, 10, 20);
    push(7, 255, 20, 45);
    settle();
    check_cnts("wrap", 2, 0, 1);
    flush_expect("wrap", 2, 250, 25, 45);
    do_reset();
    push(10, 4, 6, 30);
    push(16, 10, 2, 25);
    settle();
    check_cnts("abut", 2, 0, 1);
    flush_expect("abut", 10, 4, 8, 30);

    // randomized phase
    do_reset();
    score_thresh = 8'($urandom_range(20, 120));
    rand_ready = 1;
    ls = 0; lq = 0; ll = 0;
    for (int i = 0; i < 300; i++) begin
      if (i > 0 && $urandom_range(0, 2) != 0) begin
        q = (lq + int'($urandom_range(0, ll + 2))) % 256;
        s = (q + ls - lq + 512) % 256;
      end else begin
        s = int'($urandom_range(0, 255));
        q = int'($urandom_range(0, 255));
      end
      if ($urandom_range(0, 9) == 0) l = 0;
      else if ($urandom_range(0, 3) == 0) l = int'($urandom_range(150, 255));
      else l = int'($urandom_range(1, 60));
      sc = int'($urandom_range(0, 255));
      push(s, q, l, sc);
      if (l != 0) begin
        ls = s; lq = q; ll = l;
      end
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end
    rand_ready = 0;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    settle();
    check("rand_cnt_in", cnt_in, CW'(m_in));
    check("rand_cnt_drop", cnt_drop, CW'(m_drop));
    check("rand_cnt_merge", cnt_merge, CW'(m_merge));
    check("rand_held_v", dbg_held_v, m_hv);
    model_flush();
    flush = 1'b1;
    k = 0;
    while ((exp_q.size() > 0 || out_valid) && k < 60) begin
      @(negedge clk);
      k++;
    end
    check("rand_drained", exp_q.size(), 64'd0);
    flush = 1'b0;
    repeat (4) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
